// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle control FSM for an RV32I core: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath enables and selects, traps on unsupported encodings and counts retires.
`timescale 1ns/1ps
module rv32i_mc_ctrl #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 imem_rdy,
  input  logic                 dmem_rdy,
  input  logic [6:0]           opcode,
  input  logic [2:0]           f3,
  input  logic [6:0]           f7,
  input  logic                 br_taken,
  output logic                 imem_req,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic [3:0]           alu_op,
  output logic                 alu_a_sel,
  output logic                 alu_b_sel,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic                 trap,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic [INSTRET_W-1:0] r_instret;
  logic                 w_retire;

  // SYSTEM and every opcode outside the supported set fall to the default arm.
  function automatic logic f_is_legal(input logic [6:0] opc, input logic [2:0] fn3,
                                      input logic [6:0] fn7);
    logic ok;
    ok = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_FENCE: ok = 1'b1;
      OPC_OP: begin
        if (fn7 == 7'h00) begin
          ok = 1'b1;
        end else if (fn7 == 7'h20) begin
          ok = (fn3 == 3'b000) || (fn3 == 3'b101);
        end else begin
          ok = 1'b0;
        end
      end
      OPC_OPIMM: begin
        if (fn3 == 3'b101) begin
          ok = (fn7 == 7'h00) || (fn7 == 7'h20);
        end else if (fn3 == 3'b001) begin
          ok = (fn7 == 7'h00);
        end else begin
          ok = 1'b1;
        end
      end
      OPC_BRANCH: ok = (fn3 != 3'b010) && (fn3 != 3'b011);
      OPC_LOAD:   ok = (fn3 != 3'b011) && (fn3 != 3'b110) && (fn3 != 3'b111);
      OPC_STORE:  ok = (fn3 <= 3'b010);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] f_alu_op(input logic [2:0] fn3, input logic sub_sel,
                                          input logic sra_sel);
    logic [3:0] op;
    case (fn3)
      3'b000:  op = sub_sel ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = sra_sel ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; an undefined encoding parks in TRAP rather than resuming execution
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: begin
        if (imem_rdy) begin
          w_state_nxt = S_DECODE;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_DECODE: begin
        if (f_is_legal(opcode, f3, f7)) begin
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_TRAP;
        end
      end
      S_EXEC: begin
        if ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) begin
          w_state_nxt = S_MEM;
        end else if (opcode == OPC_BRANCH) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (!dmem_rdy) begin
          w_state_nxt = S_MEM;
        end else if (opcode == OPC_STORE) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_WB:    w_state_nxt = S_FETCH;
      S_TRAP:  w_state_nxt = S_TRAP;
      default: w_state_nxt = S_TRAP;
    endcase
  end

  // Output decode; everything is held at 0 while rst_n is low
  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    alu_op    = ALU_ADD;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    trap      = 1'b0;
    w_retire  = 1'b0;
    if (!rst_n) begin
      imem_req = 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_rdy;
        end
        S_DECODE: begin
          imem_req = 1'b0;
        end
        S_EXEC: begin
          case (opcode)
            OPC_OP: alu_op = f_alu_op(f3, f7[5], f7[5]);
            OPC_OPIMM: begin
              alu_op    = f_alu_op(f3, 1'b0, f7[5]);
              alu_b_sel = 1'b1;
            end
            OPC_LUI: begin
              alu_op    = ALU_PASSB;
              alu_b_sel = 1'b1;
            end
            OPC_AUIPC: begin
              alu_a_sel = 1'b1;
              alu_b_sel = 1'b1;
            end
            OPC_LOAD, OPC_STORE, OPC_JALR: alu_b_sel = 1'b1;
            OPC_BRANCH: begin
              alu_op   = ALU_SUB;
              pc_we    = 1'b1;
              pc_sel   = br_taken ? PC_IMM : PC_PLUS4;
              w_retire = 1'b1;
            end
            default: alu_op = ALU_ADD;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (opcode == OPC_STORE);
          if (dmem_rdy && (opcode == OPC_STORE)) begin
            pc_we    = 1'b1;
            w_retire = 1'b1;
          end else begin
            pc_we    = 1'b0;
          end
        end
        S_WB: begin
          pc_we    = 1'b1;
          w_retire = 1'b1;
          rf_we    = (opcode != OPC_FENCE);
          // JALR target comes straight off the ALU, so its operands stay selected here
          case (opcode)
            OPC_LOAD: wb_sel = WB_MEM;
            OPC_JAL: begin
              wb_sel = WB_PC4;
              pc_sel = PC_IMM;
            end
            OPC_JALR: begin
              wb_sel    = WB_PC4;
              pc_sel    = PC_ALU;
              alu_b_sel = 1'b1;
            end
            default: wb_sel = WB_ALU;
          endcase
        end
        S_TRAP: begin
          trap = 1'b1;
        end
        default: begin
          trap = 1'b0;
        end
      endcase
    end
  end

  // Retired-instruction counter, wraps naturally at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + INSTRET_W'(1);
    end else begin
      r_instret <= r_instret;
    end
  end

  assign state   = r_state;
  assign instret = r_instret;

endmodule
